// File: rtl/snake_pkg.sv
// Shared snake-game types: game-status encodings, grid bounds and the spawn FSM states.
// Also holds the helper that folds raw LFSR bits into an in-bounds coordinate.
package snake_pkg;

  localparam int COORD_W = 6;

  typedef enum logic [1:0] {
    GS_RESTART = 2'b00,
    GS_START   = 2'b01,
    GS_PLAY    = 2'b10
  } game_status_e;

  localparam logic [COORD_W-1:0] X_MIN = 6'd1;
  localparam logic [COORD_W-1:0] X_MAX = 6'd37;
  localparam logic [COORD_W-1:0] Y_MIN = 6'd1;
  localparam logic [COORD_W-1:0] Y_MAX = 6'd27;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GEN,
    ST_QUERY,
    ST_DONE
  } spawn_state_e;

  typedef enum logic {
    OWN_APPLE = 1'b0,
    OWN_MINE  = 1'b1
  } owner_e;

  // Modulo fold keeps the result strictly inside the playable area, so walls never appear.
  function automatic logic [COORD_W-1:0] map_coord(input logic [COORD_W-1:0] raw,
                                                   input logic [COORD_W-1:0] lo,
                                                   input logic [COORD_W-1:0] hi);
    logic [COORD_W-1:0] span;
    span = hi - lo + 6'd1;
    return (raw % span) + lo;
  endfunction

endpackage

// File: rtl/spawn_scheduler_if.sv
// Board-occupancy lookup port: the scheduler queries one cell, the memory answers ack/hit.
interface spawn_scheduler_if;
  import snake_pkg::*;

  logic               occ_req;
  logic [COORD_W-1:0] occ_x;
  logic [COORD_W-1:0] occ_y;
  logic               occ_ack;
  logic               occ_hit;

  modport master (output occ_req, occ_x, occ_y, input occ_ack, occ_hit);
  modport slave  (input occ_req, occ_x, occ_y, output occ_ack, occ_hit);

endinterface

// File: rtl/spawn_lfsr.sv
// Free-running 16-bit Galois LFSR and the candidate cell it maps to.
module spawn_lfsr
  import snake_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  output logic [15:0]        lfsr,
  output logic [COORD_W-1:0] cand_x,
  output logic [COORD_W-1:0] cand_y
);

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
    end
  end

  assign cand_x = map_coord(lfsr[5:0], X_MIN, X_MAX);
  assign cand_y = map_coord(lfsr[11:6], Y_MIN, Y_MAX);

endmodule

// File: rtl/spawn_scheduler.sv
// Shares one random cell source and one occupancy port between the apple and mine spawners.
//   state | meaning
//   IDLE  | waiting for a request while playing
//   GEN   | capture candidate, reject the head cell
//   QUERY | occupancy lookup in flight
//   DONE  | one-cycle grant to the owner
module spawn_scheduler
  import snake_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          MAX_TRIES   = 8,
  parameter int          ACK_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         game_status,
  input  logic [COORD_W-1:0] head_x,
  input  logic [COORD_W-1:0] head_y,
  input  logic               apple_req,
  input  logic               mine_req,
  output logic               apple_gnt,
  output logic               mine_gnt,
  output logic [COORD_W-1:0] spawn_x,
  output logic [COORD_W-1:0] spawn_y,
  output logic               spawn_fail,
  output logic               busy,
  spawn_scheduler_if.master  occ
);

  localparam int          WAIT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(ACK_TIMEOUT - 1);
  localparam logic [3:0]  TRY_LAST  = 4'(MAX_TRIES - 1);

  spawn_state_e       state;
  owner_e             owner;
  owner_e             last_owner;
  owner_e             pick;
  logic               apple_q;
  logic               mine_q;
  logic [3:0]         tries;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [COORD_W-1:0] cand_x;
  logic [COORD_W-1:0] cand_y;
  logic               occ_req_r;
  logic [15:0]        lfsr;
  logic [COORD_W-1:0] gen_x;
  logic [COORD_W-1:0] gen_y;
  logic               play;
  logic               head_hit;
  logic               tries_out;
  logic               unused_lfsr;

  spawn_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .lfsr   (lfsr),
    .cand_x (gen_x),
    .cand_y (gen_y)
  );

  assign unused_lfsr = ^lfsr;
  assign play      = (game_status == GS_PLAY);
  assign head_hit  = (gen_x == head_x) && (gen_y == head_y);
  assign tries_out = (tries == TRY_LAST);
  assign pick      = (apple_q && (!mine_q || last_owner == OWN_MINE)) ? OWN_APPLE : OWN_MINE;

  assign apple_gnt = (state == ST_DONE) && (owner == OWN_APPLE);
  assign mine_gnt  = (state == ST_DONE) && (owner == OWN_MINE);
  assign busy      = (state != ST_IDLE);

  assign occ.occ_req = occ_req_r;
  assign occ.occ_x   = cand_x;
  assign occ.occ_y   = cand_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= OWN_APPLE;
      last_owner <= OWN_MINE;
      apple_q    <= 1'b0;
      mine_q     <= 1'b0;
      tries      <= '0;
      wait_cnt   <= '0;
      cand_x     <= '0;
      cand_y     <= '0;
      spawn_x    <= '0;
      spawn_y    <= '0;
      spawn_fail <= 1'b0;
      occ_req_r  <= 1'b0;
    end else begin
      // The owner's level request is still high while it sees its grant; mask it so it is not re-served.
      apple_q    <= apple_req && !(state == ST_DONE && owner == OWN_APPLE);
      mine_q     <= mine_req && !(state == ST_DONE && owner == OWN_MINE);
      spawn_fail <= 1'b0;
      if (state != ST_IDLE && !play) begin
        state     <= ST_IDLE;
        occ_req_r <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (play && (apple_q || mine_q)) begin
              owner      <= pick;
              last_owner <= pick;
              tries      <= '0;
              state      <= ST_GEN;
            end
          end
          ST_GEN: begin
            cand_x <= gen_x;
            cand_y <= gen_y;
            if (head_hit) begin
              if (tries_out) begin
                state      <= ST_DONE;
                spawn_fail <= 1'b1;
                spawn_x    <= gen_x;
                spawn_y    <= gen_y;
              end else begin
                tries <= tries + 4'd1;
              end
            end else begin
              state     <= ST_QUERY;
              occ_req_r <= 1'b1;
              wait_cnt  <= WAIT_LOAD;
            end
          end
          ST_QUERY: begin
            if (occ.occ_ack && !occ.occ_hit) begin
              state     <= ST_DONE;
              occ_req_r <= 1'b0;
              spawn_x   <= cand_x;
              spawn_y   <= cand_y;
            end else if (occ.occ_ack || wait_cnt == '0) begin
              occ_req_r <= 1'b0;
              spawn_x   <= cand_x;
              spawn_y   <= cand_y;
              if (tries_out) begin
                state      <= ST_DONE;
                spawn_fail <= 1'b1;
              end else begin
                tries <= tries + 4'd1;
                state <= ST_GEN;
              end
            end else begin
              wait_cnt <= wait_cnt - WAIT_W'(1);
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spawn_scheduler.sv
// Scoreboard bench for spawn_scheduler: stimulus queues expected grants, a monitor checks them.
module tb_spawn_scheduler;
  import snake_pkg::*;

  localparam logic [15:0] SEED        = 16'hACE1;
  localparam int          MAX_TRIES   = 8;
  localparam int          ACK_TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] game_status;
  logic [5:0] head_x, head_y;
  logic       apple_req, mine_req;
  logic       apple_gnt, mine_gnt, spawn_fail, busy;
  logic [5:0] spawn_x, spawn_y;

  spawn_scheduler_if occ_bus ();

  spawn_scheduler #(
    .LFSR_SEED   (SEED),
    .MAX_TRIES   (MAX_TRIES),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .game_status (game_status),
    .head_x      (head_x),
    .head_y      (head_y),
    .apple_req   (apple_req),
    .mine_req    (mine_req),
    .apple_gnt   (apple_gnt),
    .mine_gnt    (mine_gnt),
    .spawn_x     (spawn_x),
    .spawn_y     (spawn_y),
    .spawn_fail  (spawn_fail),
    .busy        (busy),
    .occ         (occ_bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit mine;
    bit fail;
    int nq;
    bit chk_xy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic int exp_x(input logic [15:0] l);
    logic [5:0] r;
    r = l[5:0];
    return (int'(r) % 37) + 1;
  endfunction

  function automatic int exp_y(input logic [15:0] l);
    logic [5:0] r;
    r = l[11:6];
    return (int'(r) % 27) + 1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference LFSR, advanced on the same edges as the design's.
  logic [15:0] lfsr_m, lfsr_prev;
  always @(posedge clk) begin
    lfsr_prev <= lfsr_m;
    lfsr_m    <= rst ? SEED : ({1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000));
  end

  // Occupancy memory model and head driver.
  bit ack_en = 1'b1;
  int hit_count = 0;
  int acks_done = 0;
  bit head_track = 1'b0;
  always @(negedge clk) begin
    if (occ_bus.occ_req && ack_en) begin
      occ_bus.occ_ack = 1'b1;
      occ_bus.occ_hit = (acks_done < hit_count);
      acks_done++;
    end else begin
      occ_bus.occ_ack = 1'b0;
      occ_bus.occ_hit = 1'b0;
    end
    if (head_track) begin
      head_x = 6'(exp_x(lfsr_m));
      head_y = 6'(exp_y(lfsr_m));
    end else begin
      head_x = 6'd0;
      head_y = 6'd0;
    end
  end

  // Monitor: query checks and scoreboard pops on every grant.
  int queries = 0;
  int qlen = 0;
  int exp_qlen = 1;
  bit prev_req = 1'b0;
  bit prev_gnt = 1'b0;
  int last_x = 0;
  int last_y = 0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (!busy) queries = 0;
      if (occ_bus.occ_req && !prev_req) begin
        queries++;
        qlen   = 1;
        last_x = exp_x(lfsr_prev);
        last_y = exp_y(lfsr_prev);
        chk("occ_x", occ_bus.occ_x, last_x);
        chk("occ_y", occ_bus.occ_y, last_y);
      end else if (occ_bus.occ_req) begin
        qlen++;
      end else if (prev_req && exp_qlen != 0) begin
        chk("query_len", qlen, exp_qlen);
      end
      if (apple_gnt || mine_gnt) begin
        chk("one_grant", int'(apple_gnt && mine_gnt), 0);
        chk("gnt_pulse", int'(prev_gnt), 0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: apple=%0d mine=%0d, expected no grant", apple_gnt, mine_gnt);
        end else begin
          e = sb.pop_front();
          chk("gnt_owner_mine", int'(mine_gnt), int'(e.mine));
          chk("spawn_fail", int'(spawn_fail), int'(e.fail));
          chk("query_count", queries, e.nq);
          if (e.chk_xy) begin
            chk("spawn_x", spawn_x, last_x);
            chk("spawn_y", spawn_y, last_y);
          end
          chk("spawn_in_bounds", int'(spawn_x >= 1 && spawn_x <= 37 && spawn_y >= 1 && spawn_y <= 27), 1);
        end
      end
      prev_req = occ_bus.occ_req;
      prev_gnt = apple_gnt || mine_gnt;
    end
  end

  task automatic wait_grants(input int n, input int bound, input string name);
    int seen = 0;
    int cyc = 0;
    while (seen < n && cyc < bound) begin
      @(negedge clk);
      cyc++;
      if (apple_gnt || mine_gnt) seen++;
    end
    if (seen < n) begin
      checks++;
      errors++;
      $display("FAIL %s: timed out with %0d grants, expected %0d", name, seen, n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int t_busy, t_req, t_gnt, cyc;
    game_status = GS_RESTART;
    apple_req   = 1'b0;
    mine_req    = 1'b0;
    rst         = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_grants", int'({apple_gnt, mine_gnt, spawn_fail}), 0);
    chk("reset_spawn_xy", int'({spawn_x, spawn_y}), 0);
    chk("reset_occ", int'({occ_bus.occ_req, occ_bus.occ_x, occ_bus.occ_y}), 0);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b0;
    game_status = GS_PLAY;
    @(negedge clk);

    // Single apple request, instant free ack
    sb.push_back('{mine: 1'b0, fail: 1'b0, nq: 1, chk_xy: 1'b1});
    apple_req = 1'b1;
    t_busy = -1; t_req = -1; t_gnt = -1;
    for (int i = 1; i <= 40 && t_gnt < 0; i++) begin
      @(negedge clk);
      if (busy && t_busy < 0) t_busy = i;
      if (occ_bus.occ_req && t_req < 0) t_req = i;
      if (apple_gnt) t_gnt = i;
    end
    apple_req = 1'b0;
    chk("busy_latency", t_busy, 2);
    chk("occ_req_latency", t_req, 3);
    chk("gnt_latency", t_gnt, 4);
    repeat (3) @(negedge clk);
    chk("idle_after_gnt", int'(busy), 0);

    // Round-robin from reset: apple wins the first tie
    do_reset();
    sb.push_back('{mine: 1'b0, fail: 1'b0, nq: 1, chk_xy: 1'b1});
    sb.push_back('{mine: 1'b1, fail: 1'b0, nq: 1, chk_xy: 1'b1});
    sb.push_back('{mine: 1'b0, fail: 1'b0, nq: 1, chk_xy: 1'b1});
    sb.push_back('{mine: 1'b1, fail: 1'b0, nq: 1, chk_xy: 1'b1});
    apple_req = 1'b1;
    mine_req  = 1'b1;
    wait_grants(4, 200, "round_robin");
    apple_req = 1'b0;
    mine_req  = 1'b0;
    repeat (4) @(negedge clk);

    // Three occupied answers, fourth candidate is free
    hit_count = 3;
    acks_done = 0;
    sb.push_back('{mine: 1'b1, fail: 1'b0, nq: 4, chk_xy: 1'b1});
    mine_req = 1'b1;
    wait_grants(1, 200, "occupied_retries");
    mine_req = 1'b0;
    repeat (3) @(negedge clk);

    // Every cell occupied: fail after MAX_TRIES queries
    hit_count = 1000;
    acks_done = 0;
    sb.push_back('{mine: 1'b1, fail: 1'b1, nq: MAX_TRIES, chk_xy: 1'b1});
    mine_req = 1'b1;
    wait_grants(1, 200, "exhaustion");
    mine_req = 1'b0;
    repeat (3) @(negedge clk);

    // No ack at all: each query times out
    ack_en   = 1'b0;
    exp_qlen = ACK_TIMEOUT;
    sb.push_back('{mine: 1'b0, fail: 1'b1, nq: MAX_TRIES, chk_xy: 1'b1});
    apple_req = 1'b1;
    wait_grants(1, 400, "ack_timeout");
    apple_req = 1'b0;
    repeat (3) @(negedge clk);
    exp_qlen = 1;

    // Head always on the candidate: fail with no queries
    ack_en     = 1'b1;
    hit_count  = 0;
    head_track = 1'b1;
    sb.push_back('{mine: 1'b0, fail: 1'b1, nq: 0, chk_xy: 1'b0});
    apple_req = 1'b1;
    wait_grants(1, 100, "head_collision");
    apple_req  = 1'b0;
    head_track = 1'b0;
    repeat (3) @(negedge clk);

    // Abort during QUERY, then resume
    ack_en    = 1'b0;
    exp_qlen  = 0;
    apple_req = 1'b1;
    cyc = 0;
    while (!occ_bus.occ_req && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_reached_query", int'(occ_bus.occ_req), 1);
    game_status = GS_RESTART;
    @(negedge clk);
    chk("abort_occ_req", int'(occ_bus.occ_req), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_no_grant", int'(apple_gnt || mine_gnt), 0);
    repeat (5) @(negedge clk);
    chk("abort_stays_idle", int'(busy), 0);
    ack_en    = 1'b1;
    hit_count = 0;
    exp_qlen  = 1;
    sb.push_back('{mine: 1'b0, fail: 1'b0, nq: 1, chk_xy: 1'b1});
    game_status = GS_PLAY;
    wait_grants(1, 50, "abort_resume");
    apple_req = 1'b0;
    repeat (5) @(negedge clk);

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
